fir_decimator: RTL and testbench



---
 rtl/fir_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/fir_decimator.sv | 80 ++++++++
 tb/tb_fir_decimator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR chain: sample type, width helpers and the
// default decimation geometry, so the filter and the decimator agree on widths.
package fir_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  localparam int FIR_DATA_WIDTH = 10;
  localparam int FIR_DECIM      = 4;
  localparam int FIR_LOG2D      = clog2(FIR_DECIM);

  typedef logic signed [FIR_DATA_WIDTH-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop frees the head slot in the same cycle.
module sync_fifo
  import fir_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty FIFO presents zero so the head reads clean after reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage carries no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_decimator.sv
// Boxcar accumulate-and-dump decimator with rounding, buffered by a small
// FIFO on a valid/ready output; sticky overflow marks dropped results.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int DECIM      = FIR_DECIM,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         clr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [clog2(DEPTH):0]        level,
  output logic                         overflow
);

  localparam int LOG2D = clog2(DECIM);
  localparam int AW    = DATA_WIDTH + LOG2D;
  localparam int PW    = (LOG2D > 0) ? LOG2D : 1;
  localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

  logic [PW-1:0]                phase;
  logic signed [AW-1:0]         acc, sum, rounded;
  logic signed [DATA_WIDTH-1:0] result;
  logic                         dump, pop, full, empty;

  assign sum = acc + AW'(in_data);

  // Half-LSB bias before the arithmetic shift gives round-half-up.
  if (LOG2D == 0) begin : g_no_round
    assign rounded = sum;
  end else begin : g_round
    assign rounded = sum + AW'(1 << (LOG2D - 1));
  end

  assign result    = DATA_WIDTH'(rounded >>> LOG2D);
  assign dump      = in_valid && !clr && (phase == LAST);
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase    <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid) begin
        if (phase == LAST) begin
          phase <= '0;
          acc   <= '0;
        end else begin
          phase <= phase + PW'(1);
          acc   <= sum;
        end
      end
      if (dump && full && !pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (dump),
    .pop   (pop),
    .din   (result),
    .dout  (out_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// Self-checking bench for fir_decimator: table vectors, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_fir_decimator;
  import fir_pkg::*;

  localparam int W = 10;
  localparam int D = 4;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, clr, out_ready;
  sample_t       in_data;
  logic          out_valid, overflow;
  sample_t       out_data;
  logic [2:0]    level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: partial group, buffered results, sticky flag.
  int grp_cnt, grp_sum;
  int q[$];
  bit ovf_m;

  typedef struct {
    int s0, s1, s2, s3;
    int exp;
  } vec_t;
  vec_t vecs[4];

  fir_decimator #(.DATA_WIDTH(W), .DECIM(D), .DEPTH(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Average of D samples rounded half-up, via floor division of plain integers.
  function automatic int avg_round(input int s);
    int n, qt;
    n  = s + D / 2;
    qt = n / D;
    if ((n % D != 0) && (n < 0)) qt--;
    return qt;
  endfunction

  task automatic compare_all();
    check("out_valid", int'(out_valid), (q.size() > 0) ? 1 : 0);
    check("out_data",  int'(out_data),  (q.size() > 0) ? q[0] : 0);
    check("level",     int'(level),     q.size());
    check("overflow",  int'(overflow),  int'(ovf_m));
  endtask

  // Apply one cycle of inputs, advance the model, then sample after the edge.
  task automatic step(input bit iv, input int d, input bit rdy, input bit c);
    bit pop, push;
    int res;
    in_valid  = iv;
    in_data   = W'(d);
    out_ready = rdy;
    clr       = c;
    pop  = (q.size() > 0) && rdy;
    push = 1'b0;
    res  = 0;
    if (c) begin
      grp_cnt = 0;
      grp_sum = 0;
      ovf_m   = 1'b0;
    end else if (iv) begin
      grp_sum += d;
      grp_cnt++;
      if (grp_cnt == D) begin
        push    = 1'b1;
        res     = avg_round(grp_sum);
        grp_cnt = 0;
        grp_sum = 0;
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < N) q.push_back(res);
      else ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    compare_all();
  endtask

  task automatic group(input int v, input bit rdy);
    for (int i = 0; i < D; i++) step(1'b1, v, rdy, 1'b0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = W'(77);
    grp_cnt  = 0;
    grp_sum  = 0;
    ovf_m    = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; clr = 1'b0; out_ready = 1'b0;
    vecs[0] = '{1, 2, 3, 4, 3};
    vecs[1] = '{-1, -2, -3, -4, -2};
    vecs[2] = '{511, 511, 511, 511, 511};
    vecs[3] = '{-512, -512, -512, -512, -512};

    #1;
    do_reset();
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data",  int'(out_data),  0);
    check("reset_level",     int'(level),     0);
    check("reset_overflow",  int'(overflow),  0);

    // Rounding, negatives and extremes from the vector table.
    foreach (vecs[k]) begin
      step(1'b1, vecs[k].s0, 1'b1, 1'b0);
      step(1'b1, vecs[k].s1, 1'b1, 1'b0);
      step(1'b1, vecs[k].s2, 1'b1, 1'b0);
      check("table_no_early_valid", int'(out_valid), 0);
      step(1'b1, vecs[k].s3, 1'b1, 1'b0);
      check("table_out_valid", int'(out_valid), 1);
      check("table_out_data",  int'(out_data),  vecs[k].exp);
      check("table_level",     int'(level),     1);
      step(1'b0, 0, 1'b1, 1'b0);
      check("table_drained", int'(level), 0);
    end

    // Backpressure: five groups into a four-deep FIFO drops the last one.
    for (int g = 0; g < 5; g++) group(100, 1'b0);
    check("bp_level",    int'(level),    4);
    check("bp_overflow", int'(overflow), 1);

    // clr with a third sample: sample discarded, flag cleared, FIFO kept.
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b1, 10, 1'b0, 1'b1);
    check("clr_overflow", int'(overflow), 0);
    check("clr_level",    int'(level),    4);
    for (int i = 0; i < N; i++) begin
      check("drain_data", int'(out_data), 100);
      step(1'b0, 0, 1'b1, 1'b0);
    end
    check("drain_empty", int'(out_valid), 0);
    group(20, 1'b0);
    check("clr_realign", int'(out_data), 20);
    step(1'b0, 0, 1'b1, 1'b0);

    // Full FIFO with a pop in the same cycle as a dump.
    for (int g = 1; g <= 4; g++) group(10 * g, 1'b0);
    check("full_level", int'(level), 4);
    for (int i = 0; i < D - 1; i++) step(1'b1, 50, 1'b0, 1'b0);
    step(1'b1, 50, 1'b1, 1'b0);
    check("pp_level",    int'(level),    4);
    check("pp_overflow", int'(overflow), 0);
    check("pp_head",     int'(out_data), 20);
    for (int i = 0; i < N; i++) step(1'b0, 0, 1'b1, 1'b0);
    check("pp_empty", int'(out_valid), 0);

    // Reset with three buffered results and a partial group.
    for (int g = 0; g < 3; g++) group(-7, 1'b0);
    step(1'b1, 60, 1'b0, 1'b0);
    step(1'b1, 60, 1'b0, 1'b0);
    check("pre_rst_level", int'(level), 3);
    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_level",     int'(level),     0);
    check("rst_overflow",  int'(overflow),  0);
    check("rst_out_data",  int'(out_data),  0);
    group(8, 1'b0);
    check("post_rst_data", int'(out_data), 8);
    step(1'b0, 0, 1'b1, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 9) < 7), $signed($urandom_range(0, 1023)) - 512,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) < 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
